// File: rtl/image_pad.sv
// -----------------------------------------------------------------------------
// image_pad
// AXI4-Stream video border inserter. Accepts an IMG_WIDTH x IMG_HEIGHT beat
// frame and emits a (PAD_LEFT+IMG_WIDTH+PAD_RIGHT) x
// (PAD_TOP+IMG_HEIGHT+PAD_BOTTOM) frame. Border beats carry PAD_VALUE. Output
// tuser/tlast are regenerated from the output raster position. The output is
// a single register stage with full ready/valid backpressure.
//
// Ports
//   I_clk     : clock
//   I_rst     : synchronous reset, active-high
//   I_tdata   : input pixel beat
//   I_tvalid  : input beat valid
//   I_tready  : input beat accepted when I_tvalid && I_tready
//   I_tuser   : input start of frame (first beat)
//   I_tlast   : input end of line
//   O_tdata   : output beat (registered)
//   O_tvalid  : output valid (registered)
//   O_tready  : downstream ready
//   O_tuser   : high on output beat (0,0) only
//   O_tlast   : high on the last output column of every line
//   O_err     : one-cycle pulse on an input framing error
// -----------------------------------------------------------------------------
module image_pad #(
   parameter int                    IMG_WIDTH  = 160,
   parameter int                    IMG_HEIGHT = 480,
   parameter int                    DATA_WIDTH = 96,
   parameter int                    PAD_TOP    = 2,
   parameter int                    PAD_BOTTOM = 2,
   parameter int                    PAD_LEFT   = 2,
   parameter int                    PAD_RIGHT  = 2,
   parameter logic [DATA_WIDTH-1:0] PAD_VALUE  = '0
) (
   input  logic                  I_clk,
   input  logic                  I_rst,
   input  logic [DATA_WIDTH-1:0] I_tdata,
   input  logic                  I_tvalid,
   output logic                  I_tready,
   input  logic                  I_tuser,
   input  logic                  I_tlast,
   output logic [DATA_WIDTH-1:0] O_tdata,
   output logic                  O_tvalid,
   input  logic                  O_tready,
   output logic                  O_tuser,
   output logic                  O_tlast,
   output logic                  O_err
);

   localparam int OW = PAD_LEFT + IMG_WIDTH + PAD_RIGHT;
   localparam int OH = PAD_TOP + IMG_HEIGHT + PAD_BOTTOM;

   localparam logic [13:0] C_OW_M1    = 14'(OW - 1);
   localparam logic [13:0] C_OH_M1    = 14'(OH - 1);
   localparam logic [13:0] C_PL       = 14'(PAD_LEFT);
   localparam logic [13:0] C_PT       = 14'(PAD_TOP);
   localparam logic [13:0] C_IW       = 14'(IMG_WIDTH);
   localparam logic [13:0] C_IH       = 14'(IMG_HEIGHT);
   localparam logic [13:0] C_IMG_LAST = 14'(PAD_LEFT + IMG_WIDTH - 1);

   typedef enum logic {
      S_IDLE,
      S_FRAME
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [13:0]           r_oh;
   logic [13:0]           r_ov;
   logic [13:0]           w_oh_nxt;
   logic [13:0]           w_ov_nxt;

   logic [DATA_WIDTH-1:0] r_tdata_p1;
   logic                  r_vld_p1;
   logic                  r_tuser_p1;
   logic                  r_tlast_p1;
   logic                  r_err_p1;
   logic [DATA_WIDTH-1:0] w_tdata_nxt;
   logic                  w_vld_nxt;
   logic                  w_tuser_nxt;
   logic                  w_tlast_nxt;
   logic                  w_err_nxt;

   logic                  w_load;
   logic                  w_img;
   logic                  w_first_img;
   logic                  w_img_last_col;
   logic                  w_adv;

   // Output register may take a new beat when empty or being drained.
   assign w_load = !r_vld_p1 || O_tready;

   // Offset subtraction wraps for positions left/above the image, so one
   // unsigned compare covers both bounds (and stays valid when a pad is 0).
   assign w_img          = ((r_oh - C_PL) < C_IW) && ((r_ov - C_PT) < C_IH);
   assign w_first_img    = (r_oh == C_PL) && (r_ov == C_PT);
   assign w_img_last_col = (r_oh == C_IMG_LAST);

   always_comb begin
      w_state_nxt = r_state;
      w_oh_nxt    = r_oh;
      w_ov_nxt    = r_ov;
      w_tdata_nxt = r_tdata_p1;
      w_vld_nxt   = r_vld_p1;
      w_tuser_nxt = r_tuser_p1;
      w_tlast_nxt = r_tlast_p1;
      w_err_nxt   = 1'b0;
      w_adv       = 1'b0;
      I_tready    = 1'b0;

      case (r_state)
         S_IDLE: begin
            // Beats without start-of-frame are dropped to resynchronise; the
            // tuser beat itself stays on the bus for the first image slot.
            I_tready = I_tvalid && !I_tuser;
            if (w_load) begin
               w_vld_nxt = 1'b0;
            end
            if (I_tvalid && I_tuser) begin
               w_state_nxt = S_FRAME;
            end
         end

         S_FRAME: begin
            if (w_img) begin
               I_tready = w_load;
               if (w_load) begin
                  if (I_tvalid) begin
                     w_adv       = 1'b1;
                     w_tdata_nxt = I_tdata;
                     w_err_nxt   = (I_tuser && !w_first_img) ||
                                   (I_tlast != w_img_last_col);
                  end else begin
                     // Input starved: emit a bubble and hold position.
                     w_vld_nxt = 1'b0;
                  end
               end
            end else if (w_load) begin
               w_adv       = 1'b1;
               w_tdata_nxt = PAD_VALUE;
            end

            if (w_adv) begin
               w_vld_nxt   = 1'b1;
               w_tuser_nxt = (r_oh == '0) && (r_ov == '0);
               w_tlast_nxt = (r_oh == C_OW_M1);
               if (r_oh == C_OW_M1) begin
                  w_oh_nxt = '0;
                  if (r_ov == C_OH_M1) begin
                     w_ov_nxt    = '0;
                     w_state_nxt = S_IDLE;
                  end else begin
                     w_ov_nxt = r_ov + 14'd1;
                  end
               end else begin
                  w_oh_nxt = r_oh + 14'd1;
               end
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ---- p1: output register stage ----
   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         r_state    <= S_IDLE;
         r_oh       <= '0;
         r_ov       <= '0;
         r_tdata_p1 <= '0;
         r_vld_p1   <= 1'b0;
         r_tuser_p1 <= 1'b0;
         r_tlast_p1 <= 1'b0;
         r_err_p1   <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_oh       <= w_oh_nxt;
         r_ov       <= w_ov_nxt;
         r_tdata_p1 <= w_tdata_nxt;
         r_vld_p1   <= w_vld_nxt;
         r_tuser_p1 <= w_tuser_nxt;
         r_tlast_p1 <= w_tlast_nxt;
         r_err_p1   <= w_err_nxt;
      end
   end

   assign O_tdata  = r_tdata_p1;
   assign O_tvalid = r_vld_p1;
   assign O_tuser  = r_tuser_p1;
   assign O_tlast  = r_tlast_p1;
   assign O_err    = r_err_p1;

endmodule

// File: tb/tb_image_pad.sv
module tb_image_pad;

   localparam int             DW    = 16;
   localparam int             W     = 4;
   localparam int             H     = 2;
   localparam logic [DW-1:0]  PADV  = 16'hC3C3;
   localparam int             LIMIT = 2000;

   typedef struct packed {
      logic [DW-1:0] d;
      logic          u;
      logic          l;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] i_data;
   logic          i_valid;
   logic          i_user;
   logic          i_last;
   logic          o_ready;
   logic          sel;

   logic          a_tready, a_tvalid, a_tuser, a_tlast, a_err;
   logic [DW-1:0] a_tdata;
   logic          b_tready, b_tvalid, b_tuser, b_tlast, b_err;
   logic [DW-1:0] b_tdata;

   logic          m_tready, m_vld, m_user, m_last, m_err;
   logic [DW-1:0] m_data;

   always #5 clk = ~clk;

   // Padded instance: one border beat/line on every side.
   image_pad #(
      .IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_WIDTH(DW),
      .PAD_TOP(1), .PAD_BOTTOM(1), .PAD_LEFT(1), .PAD_RIGHT(1),
      .PAD_VALUE(PADV)
   ) u_dut_a (
      .I_clk(clk), .I_rst(rst),
      .I_tdata(i_data), .I_tvalid(i_valid && !sel), .I_tready(a_tready),
      .I_tuser(i_user), .I_tlast(i_last),
      .O_tdata(a_tdata), .O_tvalid(a_tvalid), .O_tready(o_ready && !sel),
      .O_tuser(a_tuser), .O_tlast(a_tlast), .O_err(a_err)
   );

   // Zero-pad instance: plain pass-through register.
   image_pad #(
      .IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_WIDTH(DW),
      .PAD_TOP(0), .PAD_BOTTOM(0), .PAD_LEFT(0), .PAD_RIGHT(0),
      .PAD_VALUE(PADV)
   ) u_dut_b (
      .I_clk(clk), .I_rst(rst),
      .I_tdata(i_data), .I_tvalid(i_valid && sel), .I_tready(b_tready),
      .I_tuser(i_user), .I_tlast(i_last),
      .O_tdata(b_tdata), .O_tvalid(b_tvalid), .O_tready(o_ready && sel),
      .O_tuser(b_tuser), .O_tlast(b_tlast), .O_err(b_err)
   );

   assign m_tready = sel ? b_tready : a_tready;
   assign m_vld    = sel ? b_tvalid : a_tvalid;
   assign m_data   = sel ? b_tdata  : a_tdata;
   assign m_user   = sel ? b_tuser  : a_tuser;
   assign m_last   = sel ? b_tlast  : a_tlast;
   assign m_err    = sel ? b_err    : a_err;

   // ---------------- monitor ----------------
   int            cyc = 0;
   beat_t         out_q[$];
   int            out_cyc[$];
   int            in_cyc[$];
   int            err_cyc = 0;
   int            stall_bad = 0;
   int            stall_seen = 0;
   logic          prev_stall = 1'b0;
   logic [DW-1:0] prev_d = '0;
   logic          prev_u = 1'b0;
   logic          prev_l = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst) begin
         prev_stall <= 1'b0;
      end else begin
         if (m_err) err_cyc <= err_cyc + 1;
         if (m_vld && o_ready) begin
            out_q.push_back({m_data, m_user, m_last});
            out_cyc.push_back(cyc);
         end
         if (prev_stall) begin
            stall_seen <= stall_seen + 1;
            if (!m_vld || m_data !== prev_d || m_user !== prev_u || m_last !== prev_l)
               stall_bad <= stall_bad + 1;
         end
         prev_stall <= m_vld && !o_ready;
         prev_d     <= m_data;
         prev_u     <= m_user;
         prev_l     <= m_last;
      end
   end

   // ---------------- checking ----------------
   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
         $error("%s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [DW-1:0] pix[$];
   beat_t         src[$];
   beat_t         exp_q[$];

   // Random image plus its AXIS input beats; extra_last puts an additional
   // tlast on that column of the first line (-1: none).
   function automatic void make_frame(input int extra_last);
      pix.delete();
      src.delete();
      for (int i = 0; i < W * H; i++) begin
         logic [DW-1:0] d;
         d = DW'($urandom);
         pix.push_back(d);
         src.push_back({d, (i == 0), ((i % W) == W - 1) || (i == extra_last)});
      end
   endfunction

   // Output raster of the padded frame computed from the geometry alone.
   function automatic void model(input int pl, input int pr, input int pt, input int pb);
      int ow, oh;
      ow = pl + W + pr;
      oh = pt + H + pb;
      exp_q.delete();
      for (int r = 0; r < oh; r++) begin
         for (int c = 0; c < ow; c++) begin
            logic [DW-1:0] d;
            if (r >= pt && r < pt + H && c >= pl && c < pl + W) d = pix[(r - pt) * W + (c - pl)];
            else d = PADV;
            exp_q.push_back({d, (r == 0 && c == 0), (c == ow - 1)});
         end
      end
   endfunction

   task automatic compare_frame(input string tag, input int base);
      check($sformatf("%s.count", tag), out_q.size() - base, exp_q.size());
      for (int i = 0; i < exp_q.size() && base + i < out_q.size(); i++) begin
         check($sformatf("%s.data%0d", tag, i), out_q[base + i].d, exp_q[i].d);
         check($sformatf("%s.user%0d", tag, i), out_q[base + i].u, exp_q[i].u);
         check($sformatf("%s.last%0d", tag, i), out_q[base + i].l, exp_q[i].l);
      end
   endtask

   // Presents src beats in order, collecting output until n_exp beats arrive
   // (or stop_at beats, when stop_at > 0). Bounded by LIMIT cycles.
   task automatic drive(input beat_t s[$], input bit bp, input bit gaps,
                        input int n_exp, input int stop_at, output int n_acc);
      int idx, base, guard;
      idx   = 0;
      guard = 0;
      base  = out_q.size();
      while ((idx < s.size() || out_q.size() - base < n_exp) && guard < LIMIT) begin
         if (stop_at > 0 && out_q.size() - base >= stop_at) break;
         @(posedge clk); #1;
         o_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         if (idx < s.size() && !(gaps && $urandom_range(0, 2) == 0)) begin
            i_valid = 1'b1;
            {i_data, i_user, i_last} = s[idx];
         end else begin
            i_valid = 1'b0;
         end
         @(negedge clk); #1;
         if (i_valid && m_tready) begin
            idx++;
            in_cyc.push_back(cyc);
         end
         guard++;
      end
      check("cycle_budget", (guard < LIMIT), 1);
      n_acc = idx;
      if (stop_at == 0) begin
         @(posedge clk); #1;
         i_valid = 1'b0;
         o_ready = 1'b1;
         repeat (6) @(posedge clk);
         #1;
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int base, eb, sb, ss, ib, nacc;
      rst = 1'b1; i_valid = 1'b0; i_data = '0; i_user = 1'b0; i_last = 1'b0;
      o_ready = 1'b1; sel = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst.tvalid", a_tvalid, 0);
      check("rst.tdata",  a_tdata,  0);
      check("rst.tuser",  a_tuser,  0);
      check("rst.tlast",  a_tlast,  0);
      check("rst.err",    a_err,    0);
      check("rst.b_tvalid", b_tvalid, 0);
      rst = 1'b0;

      // Geometry: continuous input, always ready.
      make_frame(-1);
      model(1, 1, 1, 1);
      eb = err_cyc; base = out_q.size();
      drive(src, 0, 0, 24, 0, nacc);
      compare_frame("geom", base);
      check("geom.err", err_cyc - eb, 0);
      check("geom.accepted", nacc, 8);

      // Backpressure with input gaps, same frame.
      eb = err_cyc; sb = stall_bad; ss = stall_seen; base = out_q.size();
      drive(src, 1, 1, 24, 0, nacc);
      compare_frame("bp", base);
      check("bp.err", err_cyc - eb, 0);
      check("bp.stall_stable", stall_bad - sb, 0);
      check("bp.stalls_seen", (stall_seen - ss) > 0, 1);

      // Resync: three beats without tuser ahead of a fresh frame.
      make_frame(-1);
      model(1, 1, 1, 1);
      for (int k = 0; k < 3; k++) src.push_front({DW'($urandom), 1'b0, 1'b0});
      base = out_q.size();
      drive(src, 0, 0, 24, 0, nacc);
      check("resync.accepted", nacc, 11);
      compare_frame("resync", base);

      // Framing error: extra tlast on image column 2 of the first line.
      make_frame(2);
      model(1, 1, 1, 1);
      eb = err_cyc; base = out_q.size();
      drive(src, 0, 0, 24, 0, nacc);
      compare_frame("ferr", base);
      check("ferr.err_cycles", err_cyc - eb, 1);

      // Zero pads: pass-through, one cycle later.
      sel = 1'b1;
      make_frame(-1);
      model(0, 0, 0, 0);
      base = out_q.size(); ib = in_cyc.size();
      drive(src, 0, 0, 8, 0, nacc);
      compare_frame("zpad", base);
      for (int i = 0; i < 8 && base + i < out_cyc.size() && ib + i < in_cyc.size(); i++)
         check($sformatf("zpad.latency%0d", i), out_cyc[base + i] - in_cyc[ib + i], 1);

      // Mid-frame reset at output beat 10, then a complete frame.
      sel = 1'b0;
      make_frame(-1);
      drive(src, 0, 0, 24, 10, nacc);
      @(posedge clk); #1;
      rst = 1'b1; i_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      check("mreset.tvalid", a_tvalid, 0);
      make_frame(-1);
      model(1, 1, 1, 1);
      base = out_q.size();
      drive(src, 0, 0, 24, 0, nacc);
      compare_frame("mreset", base);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/image_pad.md
Name: image_pad

Overview:
- AXI4-Stream video border inserter; the inverse of the ISP border-cut stage.
- Takes an IMG_WIDTH x IMG_HEIGHT beat frame and emits a larger frame of (PAD_LEFT+IMG_WIDTH+PAD_RIGHT) x (PAD_TOP+IMG_HEIGHT+PAD_BOTTOM) beats.
- Border beats carry PAD_VALUE; output tuser/tlast are regenerated.
- Sits before scalers/convolution windows that need a frame margin. Full ready/valid backpressure, registered output.

Parameters:
IMG_WIDTH, 160, input beats per line (4 pixels per beat)
IMG_HEIGHT, 480, input lines per frame
DATA_WIDTH, 96, beat width in bits
PAD_TOP, 2, border lines inserted above
PAD_BOTTOM, 2, border lines inserted below
PAD_LEFT, 2, border beats inserted before each line
PAD_RIGHT, 2, border beats inserted after each line
PAD_VALUE, 0, DATA_WIDTH-bit fill value for border beats

Ports:
I_clk  input  1  clock
I_rst  input  1  synchronous reset, active-high
I_tdata  input  DATA_WIDTH  input pixel beat
I_tvalid  input  1  input beat valid
I_tready  output  1  input beat accepted when I_tvalid && I_tready
I_tuser  input  1  start of frame, first beat
I_tlast  input  1  end of line
O_tdata  output  DATA_WIDTH  output beat (registered)
O_tvalid  output  1  output valid (registered)
O_tready  input  1  downstream ready
O_tuser  output  1  high on output beat (0,0) only
O_tlast  output  1  high on output column OW-1 of every line
O_err  output  1  one-cycle pulse on input framing error

Behaviour:
- Definitions: OW = PAD_LEFT+IMG_WIDTH+PAD_RIGHT; OH = PAD_TOP+IMG_HEIGHT+PAD_BOTTOM. Output counters oh, ov are 14 bits.
- Image region: oh in [PAD_LEFT, PAD_LEFT+IMG_WIDTH) and ov in [PAD_TOP, PAD_TOP+IMG_HEIGHT). Everything else is border.
- Reset, synchronous on I_rst=1:
  - O_tvalid=0, O_tdata=0, O_tuser=0, O_tlast=0, O_err=0.
  - oh=ov=0, state=IDLE.
  - Reset mid-frame abandons the frame immediately; the next valid output beat is a fresh (0,0) carrying tuser.
- load = !O_tvalid || O_tready. This is the output register advance condition.
- State IDLE:
  - I_tready=1 while I_tvalid && !I_tuser; those beats are discarded (resync).
  - When I_tvalid && I_tuser: go to FRAME. That beat is not consumed; I_tready=0 for it.
  - O_tvalid clears when the held beat is taken.
- State FRAME, border position:
  - When load: register PAD_VALUE with O_tvalid=1 and advance the counter. I_tready=0.
- State FRAME, image position:
  - I_tready=load. When I_tvalid && load: register I_tdata with O_tvalid=1 and advance.
  - When !I_tvalid && load: O_tvalid<=0 and hold the counter (bubble).
- Flags on every registered beat: O_tuser=(oh==0 && ov==0); O_tlast=(oh==OW-1). Input tuser/tlast are never forwarded.
- Counter advance: oh wraps OW-1 -> 0 and increments ov. After beat (OW-1, OH-1) is registered: ov=0, oh=0, state=IDLE.
- Latency: one cycle from the accepting/advancing edge to O_tvalid. Throughput is 1 beat/clk with O_tready=1 and I_tvalid=1.
- Pad beats are emitted without waiting for input. With PAD_TOP>0, the top rows are output before the input tuser beat is consumed; IDLE only requires tuser presence.
- O_err pulses for one cycle on a consumed image beat in FRAME with either:
  - I_tuser=1 at an image position other than the first, or
  - I_tlast != (oh==PAD_LEFT+IMG_WIDTH-1).
- The beat is still passed through on O_err; there is no resync mid-frame.
- O_tdata holds its value while O_tvalid && !O_tready. No beat is lost or duplicated.
- All pads=0: the block is a one-register pass-through with regenerated tuser/tlast.

Test Plan:
- Geometry: W=4, H=2, all pads=1, O_tready=1, input continuous. Required output:
  - 24 beats (6x4), rows 0 and 3 all PAD_VALUE, cols 0 and 5 PAD_VALUE.
  - Image beats in input order.
  - Exactly one O_tuser (beat 0); O_tlast on beats 5, 11, 17, 23.
  - O_err never asserted.
- Backpressure: same geometry with O_tready pseudo-random 50% and I_tvalid gaps. Output sequence identical to the geometry case; O_tdata stable while stalled.
- Resync: 3 beats without tuser, then a valid frame. The 3 beats are consumed with I_tready=1 and produce no output; the frame is then correct.
- Zero pads: W=4, H=2, all pads=0. Output equals input 8 beats, delayed 1 cycle; tuser on beat 0; tlast on beats 3 and 7.
- Framing error: input tlast on image column 2 of W=4. O_err=1 for one cycle and the output beat count is unchanged at 24.
- Mid-frame reset: assert I_rst at output beat 10. The cycle after reset: O_tvalid=0. The next frame starts with O_tuser=1 at (0,0) and is complete.
